// File: rtl/dk_pkg.sv
// Shared types and helpers for the downlink serializer.
// Frame-state enum, frame-length and odd-parity functions.
package dk_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_END = 2'd2
  } dk_state_e;

  // Order bit plus one parity bit per channel word.
  function automatic int frame_len(
    input int nch,
    input int word_w
  );
    return 1 + nch * (word_w + 1);
  endfunction

  // Zero-extension does not change the XOR, so one
  // wide argument serves every word width up to 64.
  function automatic logic odd_par(
    input logic [63:0] w
  );
    return ~^w;
  endfunction

endpackage

// File: rtl/dk_frame_shift.sv
// Frame snapshot and bit selector for the downlink stream.
// Ports: clk/rst, load_i + ch_i/ord_i snapshot, idx_i -> bit_o.
module dk_frame_shift
  import dk_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int NCH    = 2,
  parameter int CNT_W  = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_i,
  input  logic [NCH-1:0][WORD_W-1:0]   ch_i,
  input  logic                         ord_i,
  input  logic [CNT_W-1:0]             idx_i,
  output logic                         bit_o
);

  logic [NCH-1:0][WORD_W-1:0] sh_q;
  logic                       ord_sh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q     <= '0;
      ord_sh_q <= 1'b0;
    end else if (load_i) begin
      sh_q     <= ch_i;
      ord_sh_q <= ord_i;
    end
  end

  logic [WORD_W-1:0] word;
  int                ch;
  int                pos;

  // Index 0 is the order bit; the rest splits into
  // channel (quotient) and bit slot (remainder), where
  // slot WORD_W is the parity bit.
  always_comb begin
    bit_o = ord_sh_q;
    word  = '0;
    ch    = 0;
    pos   = 0;
    if (idx_i != '0) begin
      pos = int'(idx_i) - 1;
      ch  = pos / (WORD_W + 1);
      pos = pos % (WORD_W + 1);
      for (int i = 0; i < NCH; i++) begin
        if (i == ch) word = sh_q[i];
      end
      if (pos == WORD_W) begin
        bit_o = odd_par(64'(word));
      end else begin
        bit_o = 1'b0;
        for (int j = 0; j < WORD_W; j++) begin
          if (j == WORD_W - 1 - pos) bit_o = word[j];
        end
      end
    end
  end

endmodule

// File: rtl/dk_downlink_serializer.sv
// Downlink telemetry serializer: live channel words + frame FSM.
// Ports: write/readback, DKSTRT/DKBSNC/DKEND in, serial + status out.
module dk_downlink_serializer
  import dk_pkg::*;
#(
  parameter  int WORD_W = 16,
  parameter  int NCH    = 2,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              ord_wr,
  input  logic              ord_val,
  input  logic              dk_start,
  input  logic              dk_bsync,
  input  logic              dk_end,
  output logic              dk_data,
  output logic              dk_bvalid,
  output logic              busy,
  output logic              downrupt,
  output logic              abort,
  output logic              stale,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [WORD_W-1:0] rd_data
);

  localparam int FL    = frame_len(NCH, WORD_W);
  localparam int CNT_W = $clog2(FL + 1);

  logic [NCH-1:0][WORD_W-1:0] ch_q;
  logic                       ord_q;
  logic [NCH-1:0]             fresh_q;
  logic [NCH-1:0]             wr_hit;

  dk_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dk_data_q;
  logic             dk_bvalid_q;
  logic             downrupt_q;
  logic             abort_q;
  logic             stale_q;
  logic             load;
  logic             bit_nxt;

  assign load = (state_q == IDLE) && dk_start;

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_hit[i] = wr_en && (int'(wr_ch) == i);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(rd_ch) == i) rd_data = ch_q[i];
    end
  end

  // A write landing on the start edge re-arms its
  // fresh flag for the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q    <= '0;
      ord_q   <= 1'b0;
      fresh_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_hit[i]) ch_q[i] <= wr_data;
      end
      if (ord_wr) ord_q <= ord_val;
      fresh_q <= (load ? '0 : fresh_q) | wr_hit;
    end
  end

  dk_frame_shift #(
    .WORD_W (WORD_W),
    .NCH    (NCH),
    .CNT_W  (CNT_W)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .ch_i   (ch_q),
    .ord_i  (ord_q),
    .idx_i  (cnt_q),
    .bit_o  (bit_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dk_data_q   <= 1'b0;
      dk_bvalid_q <= 1'b0;
      downrupt_q  <= 1'b0;
      abort_q     <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      dk_bvalid_q <= 1'b0;
      downrupt_q  <= 1'b0;
      abort_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (dk_start) begin
            state_q <= SEND;
            cnt_q   <= '0;
            if (!(&fresh_q)) stale_q <= 1'b1;
          end
        end
        SEND: begin
          if (dk_end) begin
            state_q <= IDLE;
            abort_q <= 1'b1;
          end else if (dk_bsync) begin
            dk_data_q   <= bit_nxt;
            dk_bvalid_q <= 1'b1;
            cnt_q       <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(FL - 1)) begin
              state_q <= WAIT_END;
            end
          end
        end
        WAIT_END: begin
          if (dk_end) begin
            state_q    <= IDLE;
            downrupt_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dk_data   = dk_data_q;
  assign dk_bvalid = dk_bvalid_q;
  assign downrupt  = downrupt_q;
  assign abort     = abort_q;
  assign stale     = stale_q;
  assign busy      = (state_q != IDLE);

endmodule
